cas_player: RTL and testbench

- Cassette playback stage upstream of PIA1: reads a downloaded .CAS image from a byte buffer and regenerates the CoCo FSK cassette signal.
- The output feeds PIA1 port A bit 0 (cassette comparator input).
- Playback is gated by the cassette motor relay (PIA1 CA2 output), so BASIC CLOAD/CLOADM work unmodified.

---
 rtl/cas_pkg.sv | 9 +
 rtl/cas_half_timer.sv | 20 ++
 rtl/cas_player.sv | 85 ++++++++
 tb/tb_cas_player.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cas_pkg.sv
// cas_pkg: state encoding and FSK half-period helper shared by cas_player and its timer
package cas_pkg;
  localparam int F0_HZ = 1200;
  localparam int F1_HZ = 2400;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, HIGH, LOW, DONE} cas_state_t;
  function automatic int half_period(input int clk_hz, input int f_hz);
    return clk_hz / (2 * f_hz);
  endfunction
endpackage

// File: rtl/cas_half_timer.sv
// cas_half_timer: loadable down-counter (clk, reset, clr, load, load_val, en -> expire on enabled cycle at count 1)
module cas_half_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);
  logic [W-1:0] cnt;
  assign expire = en && cnt == W'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/cas_player.sv
// cas_player: .CAS FSK playback; in clk reset motor rewind cas_len rd_data, out rd_addr cas_bit playing tape_end
module cas_player
  import cas_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              motor,
  input  logic              rewind,
  input  logic [ADDR_W-1:0] cas_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              cas_bit,
  output logic              playing,
  output logic              tape_end
);
  localparam int HALF0 = half_period(CLK_HZ, F0_HZ);
  localparam int HALF1 = half_period(CLK_HZ, F1_HZ);
  localparam int TW = $clog2(HALF0 + 1);
  cas_state_t state, state_n;
  logic [7:0] sr;
  logic [2:0] idx;
  logic [ADDR_W-1:0] addr_n;
  logic ld, ld_sel, expire, last;
  assign addr_n = &rd_addr ? rd_addr : rd_addr + 1'b1;
  assign last = idx == 3'd7;
  assign cas_bit = state == HIGH;
  assign playing = motor && (state == HIGH || state == LOW);
  assign tape_end = state == DONE;
  cas_half_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (rewind),
    .load     (ld),
    .load_val (ld_sel ? TW'(HALF1) : TW'(HALF0)),
    .en       (motor),
    .expire   (expire)
  );
  always_comb begin
    state_n = state;
    ld = 1'b0;
    ld_sel = sr[0];
    case (state)
      IDLE:  if (motor && rd_addr < cas_len) state_n = FETCH;
             else if (motor && !(cas_len == '0 && &rd_addr)) state_n = DONE;
      FETCH: state_n = LATCH;
      LATCH: begin
        state_n = HIGH;
        ld = 1'b1;
        ld_sel = rd_data[0];
      end
      HIGH:  if (expire) begin
        state_n = LOW;
        ld = 1'b1;
      end
      LOW:   if (expire) begin
        state_n = !last ? HIGH : addr_n >= cas_len ? DONE : FETCH;
        ld = !last;
        ld_sel = sr[1];
      end
      default: ;
    endcase
    if (rewind) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rd_addr <= '0;
      sr <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      if (rewind) rd_addr <= '0;
      else if (state == LOW && expire && last) rd_addr <= addr_n;
      if (state == LATCH) begin
        sr <= rd_data;
        idx <= '0;
      end else if (state == LOW && expire && !last) begin
        sr <= sr >> 1;
        idx <= idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_cas_player.sv
// tb_cas_player: scoreboard bench for cas_player at CLK_HZ=24000 (HALF0=10, HALF1=5)
module tb_cas_player;
  typedef struct {
    logic lvl;
    int   len;
  } seg_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic motor = 1'b0;
  logic rewind = 1'b0;
  logic [15:0] cas_len = '0;
  logic [15:0] rd_addr;
  logic [7:0] rd_data = '0;
  logic cas_bit, playing, tape_end;
  logic [7:0] mem [0:15];
  seg_t exp_q[$];
  int n_assert = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  int cur_len = 0;
  logic cur_lvl = 1'b0;
  int gap = 0;
  cas_player #(.CLK_HZ(24000), .ADDR_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .motor    (motor),
    .rewind   (rewind),
    .cas_len  (cas_len),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .cas_bit  (cas_bit),
    .playing  (playing),
    .tape_end (tape_end)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr[3:0]];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{1'b1, b[i] ? 5 : 10});
      exp_q.push_back('{1'b0, b[i] ? 5 : 10});
    end
  endtask
  task automatic close_seg();
    seg_t s;
    chk("seg_avail", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      chk("seg_lvl", cur_lvl, s.lvl);
      chk("seg_len", cur_len, s.len);
    end
    cur_len = 0;
  endtask
  always @(posedge clk) begin
    #1;
    if (!mon_en || reset) begin
      cur_len = 0;
      gap = 0;
    end else if (playing) begin
      if (gap > 0) chk("byte_gap", gap, 2);
      gap = 0;
      if (cur_len > 0 && cas_bit !== cur_lvl) close_seg();
      if (cur_len == 0) cur_lvl = cas_bit;
      cur_len++;
    end else if (motor) begin
      chk("idle_low", cas_bit, 0);
      if (cur_len > 0) begin
        close_seg();
        gap = tape_end ? 0 : 1;
      end else gap = (gap > 0 && !tape_end) ? gap + 1 : 0;
    end
  end
  task automatic pulse_rewind();
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
  endtask
  task automatic wait_end(input int lim);
    int n = 0;
    while (tape_end !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("tape_end_set", tape_end, 1);
  endtask
  task automatic wait_addr(input logic [15:0] a);
    int n = 0;
    while (rd_addr !== a && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("addr_step", rd_addr, a);
  endtask
  task automatic wait_cas(input logic v);
    int n = 0;
    while (cas_bit !== v && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("cas_wait", cas_bit, v);
  endtask
  initial begin
    int n, falls;
    bit ok;
    logic prev;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_addr", rd_addr, 0);
    chk("rst_cas", cas_bit, 0);
    chk("rst_play", playing, 0);
    chk("rst_end", tape_end, 0);
    reset = 1'b0;
    @(negedge clk);
    mem[0] = 8'h01;
    cas_len = 16'd1;
    push_byte(8'h01);
    mon_en = 1'b1;
    motor = 1'b1;
    wait_end(2000);
    chk("t1_addr", rd_addr, 1);
    chk("t1_q", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    chk("t1_cas_after", cas_bit, 0);
    chk("t1_end_sticky", tape_end, 1);
    mem[0] = 8'h55;
    mem[1] = 8'hAA;
    cas_len = 16'd2;
    push_byte(8'h55);
    push_byte(8'hAA);
    pulse_rewind();
    chk("t2_rw_addr", rd_addr, 0);
    chk("t2_rw_end", tape_end, 0);
    wait_addr(16'd1);
    chk("t2_mid_end", tape_end, 0);
    wait_end(2000);
    chk("t2_addr", rd_addr, 2);
    chk("t2_q", exp_q.size(), 0);
    mem[0] = 8'h00;
    cas_len = 16'd1;
    push_byte(8'h00);
    pulse_rewind();
    wait_cas(1'b1);
    repeat (3) @(negedge clk);
    motor = 1'b0;
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      ok &= (cas_bit === 1'b1) && (playing === 1'b0);
    end
    chk("t3_hold", ok, 1);
    motor = 1'b1;
    n = 0;
    while (cas_bit === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("t3_resume_len", n, 7);
    wait_end(2000);
    chk("t3_q", exp_q.size(), 0);
    mon_en = 1'b0;
    exp_q.delete();
    mem[0] = 8'h0F;
    mem[1] = 8'h3C;
    mem[2] = 8'hC3;
    mem[3] = 8'hF0;
    cas_len = 16'd4;
    pulse_rewind();
    wait_addr(16'd1);
    falls = 0;
    n = 0;
    prev = cas_bit;
    while (falls < 8 && n < 1000) begin
      @(negedge clk);
      n++;
      if (prev === 1'b1 && cas_bit === 1'b0) falls++;
      prev = cas_bit;
    end
    chk("t4_falls", falls, 8);
    repeat (9) @(negedge clk);
    chk("t4_pre_addr", rd_addr, 1);
    pulse_rewind();
    chk("t4_rw_addr", rd_addr, 0);
    chk("t4_rw_cas", cas_bit, 0);
    chk("t4_rw_play", playing, 0);
    for (int i = 0; i < 4; i++) push_byte(mem[i]);
    mon_en = 1'b1;
    wait_end(4000);
    chk("t4_addr", rd_addr, 4);
    chk("t4_q", exp_q.size(), 0);
    cas_len = 16'd0;
    pulse_rewind();
    repeat (3) @(negedge clk);
    chk("t5_end", tape_end, 1);
    chk("t5_play", playing, 0);
    chk("t5_addr", rd_addr, 0);
    mem[0] = 8'h81;
    cas_len = 16'd1;
    push_byte(8'h81);
    pulse_rewind();
    wait_end(2000);
    chk("t5_addr_after", rd_addr, 1);
    chk("t5_q", exp_q.size(), 0);
    mon_en = 1'b0;
    exp_q.delete();
    mem[0] = 8'h00;
    mem[1] = 8'h00;
    cas_len = 16'd2;
    pulse_rewind();
    wait_addr(16'd1);
    wait_cas(1'b1);
    wait_cas(1'b0);
    repeat (2) @(negedge clk);
    chk("t6_pre_play", playing, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_addr", rd_addr, 0);
    chk("t6_cas", cas_bit, 0);
    chk("t6_play", playing, 0);
    chk("t6_end", tape_end, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
